// File: rtl/smvm_result_tx_pkg.sv
// Shared types and helpers for the SMVM result transmit path.
//   SMVM_RESULT_W / SMVM_WORD_W : result and stream word widths
//   tx_state_e                  : transmit FSM encoding
//   result_entry_t              : FIFO entry {eop, data}
//   bswap32 / result_word       : word slicing and link byte order
package smvm_pkg;

  localparam int unsigned SMVM_RESULT_W = 76;
  localparam int unsigned SMVM_WORD_W   = 32;
  localparam int unsigned WIDX_W        = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic                     eop;
    logic [SMVM_RESULT_W-1:0] data;
  } result_entry_t;

  // Reverse byte order of a 32-bit word (link is big-endian).
  function automatic logic [SMVM_WORD_W-1:0] bswap32(input logic [SMVM_WORD_W-1:0] w);
    bswap32 = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Select stream word idx of a result; word 2 carries the sign-extended top bits.
  function automatic logic [SMVM_WORD_W-1:0] result_word(input logic [SMVM_RESULT_W-1:0] d,
                                                         input logic [WIDX_W-1:0]        idx);
    logic [SMVM_WORD_W-1:0] w;
    case (idx)
      2'd0:    w = d[31:0];
      2'd1:    w = d[63:32];
      default: w = {{20{d[75]}}, d[75:64]};
    endcase
    result_word = w;
  endfunction

endpackage

// File: rtl/smvm_result_tx_if.sv
// AXI-Stream send channel toward the PS send FIFO.
//   tdata/tkeep/tlast/tvalid : driven by the master (transmitter)
//   tready                   : driven by the slave (PS FIFO)
interface smvm_result_tx_if;

  logic [smvm_pkg::SMVM_WORD_W-1:0] tdata;
  logic [3:0]                       tkeep;
  logic                             tlast;
  logic                             tvalid;
  logic                             tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/smvm_result_tx_fifo.sv
// Single-clock first-word-fall-through FIFO for buffered results.
//   push_i/din_i   : write side (caller guarantees not full unless popping)
//   pop_i/dout_o   : read side, dout_o shows the head while not empty
//   count_o        : registered occupancy
//   full_o/empty_o : derived from pointers carrying an extra wrap bit
module smvm_result_fifo #(
  parameter int unsigned WIDTH = 77,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = count_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/smvm_result_tx.sv
// Transmit side of the SMVM PS/PL link: buffers 76-bit results and
// serialises each into OUT_WORDS 32-bit AXI-Stream words.
//   clk, rst_n                  : clock, async active-low reset
//   valid_i/eop_i/data_i        : SMVM result beats (no backpressure)
//   axi_send_fifo_almost_full_0 : downstream almost-full, checked per result
//   S_AXIS_Send                 : stream master toward the PS send FIFO
//   overflow_o                  : sticky, a result was dropped
//   fifo_count_o                : registered FIFO occupancy
module smvm_result_tx
  import smvm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OUT_WORDS  = 3,
  parameter bit          BYTE_SWAP  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_i,
  input  logic                          eop_i,
  input  logic [SMVM_RESULT_W-1:0]      data_i,
  input  logic                          axi_send_fifo_almost_full_0,
  smvm_result_tx_if.master              S_AXIS_Send,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned      ENTRY_W  = $bits(result_entry_t);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(OUT_WORDS - 1);

  tx_state_e              state_q, state_d;
  logic [WIDX_W-1:0]      widx_q, widx_d;
  result_entry_t          ent_q, ent_d;
  logic                   overflow_q, overflow_d;
  logic [SMVM_WORD_W-1:0] tdata_q, tdata_d;
  logic [3:0]             tkeep_q, tkeep_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;

  result_entry_t          fifo_din;
  result_entry_t          fifo_head;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   start_ok;
  logic [SMVM_WORD_W-1:0] word_raw;

  assign fifo_din  = '{eop: eop_i, data: data_i};
  // A full FIFO still accepts when the FSM drains an entry in the same cycle.
  assign fifo_push = valid_i && (!fifo_full || fifo_pop);
  assign start_ok  = !fifo_empty && !axi_send_fifo_almost_full_0;

  smvm_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, pop decision and next registered stream outputs.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    ent_d      = ent_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q | (valid_i & ~fifo_push);

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          fifo_pop = 1'b1;
          ent_d    = fifo_head;
          widx_d   = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (S_AXIS_Send.tready) begin
          if (widx_q == LAST_IDX) begin
            widx_d = '0;
            // Result boundary: chain the next entry without a bubble if allowed.
            if (start_ok) begin
              fifo_pop = 1'b1;
              ent_d    = fifo_head;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        widx_d  = '0;
      end
    endcase

    // Outputs are computed from next-state so they leave flops directly.
    tvalid_d = (state_d == ST_SEND);
    word_raw = result_word(ent_d.data, widx_d);
    tdata_d  = '0;
    if (tvalid_d) tdata_d = BYTE_SWAP ? bswap32(word_raw) : word_raw;
    tkeep_d  = tvalid_d ? 4'hF : 4'h0;
    tlast_d  = tvalid_d && ent_d.eop && (widx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      widx_q     <= '0;
      ent_q      <= '0;
      overflow_q <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      ent_q      <= ent_d;
      overflow_q <= overflow_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign S_AXIS_Send.tdata  = tdata_q;
  assign S_AXIS_Send.tkeep  = tkeep_q;
  assign S_AXIS_Send.tlast  = tlast_q;
  assign S_AXIS_Send.tvalid = tvalid_q;
  assign overflow_o         = overflow_q;

endmodule
